// File: rtl/systolic_array_sequencer_pkg.sv
// rtl/systolic_array_sequencer_pkg.sv - shared state encoding and default sizing for the sequencer
package systolic_array_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_X,
      COMPUTE,
      STORE,
      WAIT_RES,
      DRAIN
   } state_e;

   localparam int DEF_BITWIDTH = 4;
   localparam int DEF_N        = 2;
   localparam int DEF_TIMEOUT  = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/systolic_array_sequencer.sv
// rtl/systolic_array_sequencer.sv - streams weight/input nibbles into an NxN array and returns its results
module systolic_array_sequencer
   import systolic_array_sequencer_pkg::*;
#(
   parameter int BITWIDTH       = DEF_BITWIDTH,
   parameter int OUTWIDTH       = 2 * BITWIDTH,
   parameter int N              = DEF_N,
   parameter int COMPUTE_CYCLES = 3 * N - 2,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                keep_weights,
   input  logic [BITWIDTH-1:0] host_data,
   input  logic                host_valid,
   output logic                host_ready,
   output logic [BITWIDTH-1:0] sa_data,
   output logic                sa_load_weights,
   output logic                sa_load_inputs,
   output logic                sa_store_outputs,
   input  logic [OUTWIDTH-1:0] sa_results,
   input  logic                sa_valid,
   output logic [OUTWIDTH-1:0] res_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy,
   output logic                err
);

   localparam int BEATS = N * N;
   localparam int BW    = $clog2(BEATS + 1);
   localparam int CW    = $clog2(max_int(COMPUTE_CYCLES, TIMEOUT) + 1);

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_COMP = CW'(COMPUTE_CYCLES - 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [BW-1:0]       beat_cnt_q;
   logic [BW-1:0]       res_cnt_q;
   logic [CW-1:0]       cyc_cnt_q;
   logic                weights_held_q;
   logic                host_ready_q;
   logic [BITWIDTH-1:0] sa_data_q;
   logic                sa_load_weights_q;
   logic                sa_load_inputs_q;
   logic                sa_store_q;
   logic [OUTWIDTH-1:0] res_data_q;
   logic                res_valid_q;
   logic                busy_q;
   logic                err_q;

   logic beat, last_beat;

   // host_ready_q mirrors the load states, so it doubles as the beat qualifier
   assign beat      = host_valid & host_ready_q;
   assign last_beat = beat && (beat_cnt_q == LAST_BEAT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = (keep_weights && weights_held_q) ? LOAD_X : LOAD_W;
         LOAD_W:   if (last_beat) state_d = LOAD_X;
         LOAD_X:   if (last_beat) state_d = COMPUTE;
         COMPUTE:  if (cyc_cnt_q == LAST_COMP) state_d = STORE;
         STORE:    state_d = WAIT_RES;
         WAIT_RES: begin
            if (sa_valid)                    state_d = DRAIN;
            else if (cyc_cnt_q == LAST_WAIT) state_d = IDLE;
         end
         DRAIN: begin
            if (res_valid_q && res_ready)
               state_d = (res_cnt_q == LAST_BEAT) ? IDLE : STORE;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= IDLE;
         beat_cnt_q        <= '0;
         res_cnt_q         <= '0;
         cyc_cnt_q         <= '0;
         weights_held_q    <= 1'b0;
         host_ready_q      <= 1'b0;
         sa_data_q         <= '0;
         sa_load_weights_q <= 1'b0;
         sa_load_inputs_q  <= 1'b0;
         sa_store_q        <= 1'b0;
         res_data_q        <= '0;
         res_valid_q       <= 1'b0;
         busy_q            <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         state_q           <= state_d;
         busy_q            <= (state_d != IDLE);
         host_ready_q      <= (state_d == LOAD_W) || (state_d == LOAD_X);
         sa_load_weights_q <= 1'b0;
         sa_load_inputs_q  <= 1'b0;
         sa_store_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  err_q      <= 1'b0;
                  beat_cnt_q <= '0;
                  res_cnt_q  <= '0;
                  cyc_cnt_q  <= '0;
               end
            end
            LOAD_W, LOAD_X: begin
               if (beat) begin
                  sa_data_q         <= host_data;
                  sa_load_weights_q <= (state_q == LOAD_W);
                  sa_load_inputs_q  <= (state_q == LOAD_X);
                  beat_cnt_q        <= last_beat ? '0 : beat_cnt_q + 1'b1;
                  if (last_beat && state_q == LOAD_W) weights_held_q <= 1'b1;
               end
            end
            COMPUTE: cyc_cnt_q <= (state_d == COMPUTE) ? cyc_cnt_q + 1'b1 : '0;
            STORE: begin
               sa_store_q <= 1'b1;
               cyc_cnt_q  <= '0;
            end
            WAIT_RES: begin
               if (sa_valid) begin
                  res_data_q  <= sa_results;
                  res_valid_q <= 1'b1;
                  cyc_cnt_q   <= '0;
               end else if (cyc_cnt_q == LAST_WAIT) begin
                  // held weights are no longer trusted after the array went silent
                  err_q          <= 1'b1;
                  weights_held_q <= 1'b0;
                  cyc_cnt_q      <= '0;
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (res_valid_q && res_ready) begin
                  res_valid_q <= 1'b0;
                  res_cnt_q   <= res_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign host_ready       = host_ready_q;
   assign sa_data          = sa_data_q;
   assign sa_load_weights  = sa_load_weights_q;
   assign sa_load_inputs   = sa_load_inputs_q;
   assign sa_store_outputs = sa_store_q;
   assign res_data         = res_data_q;
   assign res_valid        = res_valid_q;
   assign busy             = busy_q;
   assign err              = err_q;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb/tb_systolic_array_sequencer.sv - scoreboard bench for the systolic array sequencer
module tb_systolic_array_sequencer;

   typedef struct {
      logic [3:0] d;
      int         c;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       keep_weights = 1'b0;
   logic [3:0] host_data = '0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic [3:0] sa_data;
   logic       sa_load_weights, sa_load_inputs, sa_store_outputs;
   logic [7:0] sa_results = '0;
   logic       sa_valid = 1'b0;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic       busy, err;

   systolic_array_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .keep_weights(keep_weights),
      .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
      .sa_data(sa_data), .sa_load_weights(sa_load_weights), .sa_load_inputs(sa_load_inputs),
      .sa_store_outputs(sa_store_outputs), .sa_results(sa_results), .sa_valid(sa_valid),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_w[$];
   beat_t exp_x[$];
   logic [7:0] exp_res[$];
   int    store_cnt = 0;
   int    store_cyc = 0;
   int    last_x_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: samples one time unit before each rising edge
   initial begin
      beat_t b;
      logic [7:0] r;
      forever begin
         @(negedge clk);
         #4;
         if (!reset) begin
            if (sa_load_weights) begin
               if (exp_w.size() == 0) flag("unexpected_sa_load_weights");
               else begin
                  b = exp_w.pop_front();
                  chk("w_data", 32'(sa_data), 32'(b.d));
                  chk("w_latency", 32'(cyc), 32'(b.c));
               end
            end
            if (sa_load_inputs) begin
               last_x_cyc = cyc;
               if (exp_x.size() == 0) flag("unexpected_sa_load_inputs");
               else begin
                  b = exp_x.pop_front();
                  chk("x_data", 32'(sa_data), 32'(b.d));
                  chk("x_latency", 32'(cyc), 32'(b.c));
               end
            end
            if (sa_store_outputs) begin
               store_cnt++;
               store_cyc = cyc;
            end
            if (res_valid && res_ready) begin
               if (exp_res.size() == 0) flag("unexpected_result");
               else begin
                  r = exp_res.pop_front();
                  chk("res_data", 32'(res_data), 32'(r));
               end
            end
         end
      end
   end

   // Array model: answers each store two cycles later with the next table value
   logic [7:0] vals[4] = '{8'h13, 8'h16, 8'h2B, 8'h32};
   int   ridx = 0;
   bit   model_en = 1'b1;
   logic d1 = 1'b0, d2 = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            d1 = 1'b0; d2 = 1'b0; sa_valid = 1'b0;
         end else begin
            d2 = d1;
            d1 = sa_store_outputs & model_en;
            sa_valid = d2;
            if (d2) begin
               sa_results = vals[ridx % 4];
               ridx++;
            end
         end
      end
   end

   task automatic do_start(input bit keep);
      @(negedge clk);
      start = 1'b1; keep_weights = keep;
      @(negedge clk);
      start = 1'b0; keep_weights = 1'b0;
   endtask

   task automatic send(input logic [3:0] d, input bit is_w, input int gap);
      beat_t b;
      int n;
      for (int i = 0; i < gap; i++) begin
         host_valid = 1'b0;
         @(negedge clk);
      end
      host_valid = 1'b1; host_data = d; n = 0;
      while (!host_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!host_ready) begin
         flag("beat_wait_timeout");
         host_valid = 1'b0;
         return;
      end
      b.d = d; b.c = cyc + 1;
      if (is_w) exp_w.push_back(b);
      else      exp_x.push_back(b);
      @(negedge clk);
   endtask

   task automatic load4(input logic [3:0] base, input bit is_w, input int max_gap);
      for (int i = 0; i < 4; i++) send(base + 4'(i), is_w, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      host_valid = 1'b0;
   endtask

   task automatic push_results();
      for (int i = 0; i < 4; i++) exp_res.push_back(vals[i]);
      ridx = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_store(input int base);
      int n = 0;
      while (store_cnt == base && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (store_cnt == base) flag("store_wait_timeout");
   endtask

   task automatic queues_empty(input string name);
      chk({name, "_w_left"}, 32'(exp_w.size()), 32'd0);
      chk({name, "_x_left"}, 32'(exp_x.size()), 32'd0);
      chk({name, "_res_left"}, 32'(exp_res.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, sc, n, err_cyc;
      logic [7:0] held;

      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({host_ready, sa_data, sa_load_weights, sa_load_inputs,
                                sa_store_outputs, res_data, res_valid, busy, err}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // full load, no stalls, results drained immediately
      push_results();
      base = store_cnt;
      do_start(1'b0);
      chk("busy_after_start", 32'(busy), 32'd1);
      load4(4'd1, 1'b1, 0);
      load4(4'd5, 1'b0, 0);
      wait_store(base);
      chk("compute_to_store", 32'(store_cyc - last_x_cyc), 32'd5);
      wait_idle("a_idle");
      chk("a_host_ready", 32'(host_ready), 32'd0);
      queues_empty("a");

      // held weights, random stalls on host_valid
      push_results();
      do_start(1'b1);
      chk("keep_host_ready", 32'(host_ready), 32'd1);
      load4(4'd9, 1'b0, 2);
      wait_idle("b_idle");
      queues_empty("b");

      // host back-pressure on the first result
      res_ready = 1'b0;
      push_results();
      do_start(1'b1);
      load4(4'd3, 1'b0, 0);
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("c_res_valid", 32'(res_valid), 32'd1);
      held = res_data;
      sc = store_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("c_res_stable", 32'({res_valid, res_data}), 32'({1'b1, held}));
      end
      chk("c_no_store", 32'(store_cnt), 32'(sc));
      res_ready = 1'b1;
      wait_idle("c_idle");
      queues_empty("c");

      // silent array -> timeout
      model_en = 1'b0;
      base = store_cnt;
      do_start(1'b1);
      load4(4'd7, 1'b0, 0);
      wait_store(base);
      n = 0;
      while (!err && n < 40) begin
         @(negedge clk);
         n++;
      end
      err_cyc = cyc;
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_len", 32'(err_cyc - store_cyc), 32'd16);
      chk("timeout_idle", 32'(busy), 32'd0);
      model_en = 1'b1;

      // restart clears err and reloads weights; reset lands after the 2nd input beat
      do_start(1'b1);
      chk("err_cleared", 32'(err), 32'd0);
      load4(4'd1, 1'b1, 0);
      send(4'd5, 1'b0, 0);
      send(4'd6, 1'b0, 0);
      host_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset_outputs", 32'({host_ready, sa_data, sa_load_weights, sa_load_inputs,
                                   sa_store_outputs, res_data, res_valid, busy, err}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      sc = store_cnt;
      repeat (10) @(negedge clk);
      chk("post_reset_no_store", 32'(store_cnt), 32'(sc));
      chk("post_reset_busy", 32'(busy), 32'd0);
      queues_empty("r");

      // keep_weights after reset must still load weights
      push_results();
      do_start(1'b1);
      load4(4'd1, 1'b1, 0);
      load4(4'd5, 1'b0, 0);
      wait_idle("f_idle");
      queues_empty("f");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
